// File: rtl/logicnet_lut_layer.sv
// rtl/logicnet_lut_layer.sv - layer of independent LUT neurons with table load mode
//
// Each neuron owns a 2^FAN_IN x OUT_BITS table addressed by its FAN_IN-bit slice
// of in_data. Lookups flow through a two-stage valid/ready pipeline.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready/in_data input stream, neuron n address = in_data[n*FAN_IN +: FAN_IN]
//   out_valid/out_ready/out_data result stream, neuron n result = out_data[n*OUT_BITS +: OUT_BITS]
//   cfg_req/cfg_ack           table-load handshake; cfg_ack high while in CFG
//   cfg_we/cfg_neuron/cfg_addr/cfg_data  table write port, honoured only in CFG
//   busy                      high while clearing tables (INIT) or draining (DRAIN)
module logicnet_lut_layer #(
   parameter int NUM_NEURONS = 4,
   parameter int FAN_IN      = 8,
   parameter int OUT_BITS    = 1,
   localparam int NW         = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [NUM_NEURONS*FAN_IN-1:0]   in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
   input  logic                            cfg_req,
   output logic                            cfg_ack,
   input  logic                            cfg_we,
   input  logic [NW-1:0]                   cfg_neuron,
   input  logic [FAN_IN-1:0]               cfg_addr,
   input  logic [OUT_BITS-1:0]             cfg_data,
   output logic                            busy
);

   localparam int DEPTH = 1 << FAN_IN;

   typedef enum logic [1:0] {S_INIT, S_RUN, S_DRAIN, S_CFG} state_t;

   state_t                            state, state_nxt;
   logic [FAN_IN-1:0]                 init_cnt;
   logic                              s1_valid;
   logic [NUM_NEURONS*FAN_IN-1:0]     s1_data;
   logic [NUM_NEURONS*OUT_BITS-1:0]   lut_out;
   logic                              en;
   logic                              adv;
   logic                              xfer;
   logic                              init_wr;
   logic                              cfg_wr;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_INIT;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:  if (init_cnt == '1) state_nxt = S_RUN;
         S_RUN:   if (cfg_req) state_nxt = S_DRAIN;
         S_DRAIN: if (!s1_valid && !out_valid) state_nxt = S_CFG;
         S_CFG:   if (!cfg_req) state_nxt = S_RUN;
         default: state_nxt = S_INIT;
      endcase
   end

   // Output / control decode
   always_comb begin
      en       = !out_valid || out_ready;
      in_ready = 1'b0;
      adv      = 1'b0;
      cfg_ack  = 1'b0;
      busy     = 1'b0;
      init_wr  = 1'b0;
      case (state)
         S_INIT:  begin busy = 1'b1; init_wr = 1'b1; end
         // cfg_req blocks new inputs in the very cycle it is seen
         S_RUN:   begin adv = en; in_ready = en && !cfg_req; end
         S_DRAIN: begin busy = 1'b1; adv = en; end
         S_CFG:   cfg_ack = 1'b1;
         default: busy = 1'b1;
      endcase
      xfer   = in_valid && in_ready;
      // zero-extend so an out-of-range neuron index compares correctly
      cfg_wr = cfg_ack && cfg_we && ({1'b0, cfg_neuron} < (NW+1)'(NUM_NEURONS));
   end

   // Clear counter: sweeps every address once per INIT
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          init_cnt <= '0;
      else if (init_wr) init_cnt <= init_cnt + 1'b1;
   end

   // Per-neuron distributed-RAM tables with asynchronous read
   for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
      logic [OUT_BITS-1:0] tbl [DEPTH];
      logic                we;

      assign we = cfg_wr && (cfg_neuron == NW'(n));

      always_ff @(posedge clk) begin
         if (init_wr) tbl[init_cnt]  <= '0;
         else if (we) tbl[cfg_addr]  <= cfg_data;
      end

      assign lut_out[n*OUT_BITS +: OUT_BITS] = tbl[s1_data[n*FAN_IN +: FAN_IN]];
   end

   // Two-stage pipeline; both stages hold together when the output is stalled.
   // Tables are only written in INIT/CFG, when the pipeline is empty, so a
   // write never races a lookup in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_data   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (adv) begin
         s1_valid  <= xfer;
         if (xfer) s1_data <= in_data;
         out_valid <= s1_valid;
         if (s1_valid) out_data <= lut_out;
      end
   end

endmodule

// File: tb/tb_logicnet_lut_layer.sv
// tb/tb_logicnet_lut_layer.sv - randomized self-checking bench for logicnet_lut_layer
module tb_logicnet_lut_layer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_data;
   logic        cfg_req;
   logic        cfg_ack;
   logic        cfg_we;
   logic [1:0]  cfg_neuron;
   logic [7:0]  cfg_addr;
   logic [0:0]  cfg_data;
   logic        busy;

   // second instance: 3 neurons so an out-of-range neuron index is expressible
   logic        rst2;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [11:0] b_in_data;
   logic [5:0]  b_out_data;
   logic        b_cfg_req, b_cfg_ack, b_cfg_we, b_busy;
   logic [1:0]  b_cfg_neuron;
   logic [3:0]  b_cfg_addr;
   logic [1:0]  b_cfg_data;

   int n_tests = 0;
   int n_fail  = 0;
   int n_acc   = 0;
   int n_out   = 0;

   logic        mtab [4][256];
   logic [3:0]  expq [$];
   logic        prev_stall;
   logic [3:0]  prev_data;
   logic        rnd_stop;

   logicnet_lut_layer dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .cfg_req(cfg_req), .cfg_ack(cfg_ack), .cfg_we(cfg_we),
      .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .busy(busy)
   );

   logicnet_lut_layer #(.NUM_NEURONS(3), .FAN_IN(4), .OUT_BITS(2)) dut2 (
      .clk(clk), .rst(rst2),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .cfg_req(b_cfg_req), .cfg_ack(b_cfg_ack), .cfg_we(b_cfg_we),
      .cfg_neuron(b_cfg_neuron), .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data),
      .busy(b_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] model_out(input logic [31:0] d);
      logic [3:0] r;
      for (int n = 0; n < 4; n++) r[n] = mtab[n][d[n*8 +: 8]];
      return r;
   endfunction

   function automatic logic [31:0] rnd_small();
      logic [31:0] r;
      for (int n = 0; n < 4; n++) r[n*8 +: 8] = 8'($urandom_range(0, 15));
      return r;
   endfunction

   // Scoreboard: handshakes are judged at the falling edge, where all inputs are settled
   always @(negedge clk) begin
      if (rst) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_hold_valid", out_valid, 1'b1);
            chk("stall_hold_data", out_data, prev_data);
         end
         if (in_valid && in_ready) begin
            expq.push_back(model_out(in_data));
            n_acc++;
         end
         if (out_valid && out_ready) begin
            n_out++;
            chk("out_expected", expq.size() != 0, 1'b1);
            if (expq.size() != 0) chk("out_data", out_data, expq.pop_front());
         end
         prev_stall <= out_valid && !out_ready;
         prev_data  <= out_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_init(input int exp_cycles);
      int n = 0;
      while (busy && n < 400) begin
         step();
         n++;
      end
      chk("init_cycles", n, exp_cycles);
      chk("init_in_ready", in_ready, 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0; cfg_req = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
      for (int n = 0; n < 4; n++)
         for (int a = 0; a < 256; a++) mtab[n][a] = 1'b0;
      expq.delete();
      #1;
      chk("rst_busy", busy, 1'b1);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_cfg_ack", cfg_ack, 1'b0);
      chk("rst_out_data", out_data, 4'b0000);
      repeat (3) step();
      rst = 1'b0;
      wait_init(256);
   endtask

   task automatic send(input logic [31:0] d);
      int tries = 0;
      logic acc = 1'b0;
      in_data  = d;
      in_valid = 1'b1;
      while (!acc && tries < 200) begin
         @(negedge clk);
         acc = in_ready;
         step();
         tries++;
      end
      in_valid = 1'b0;
      chk("send_accept", acc, 1'b1);
   endtask

   task automatic drain();
      int t = 0;
      while (expq.size() != 0 && t < 200) begin
         step();
         t++;
      end
      chk("drain_empty", expq.size(), 0);
   endtask

   task automatic wait_cfg_ack();
      int t = 0;
      while (!cfg_ack && t < 50) begin
         step();
         t++;
      end
      chk("cfg_ack_up", cfg_ack, 1'b1);
   endtask

   task automatic cfg_write(input int nrn, input int addr, input int data, input bit upd);
      cfg_we     = 1'b1;
      cfg_neuron = nrn[1:0];
      cfg_addr   = addr[7:0];
      cfg_data   = data[0:0];
      step();
      cfg_we = 1'b0;
      if (upd) mtab[nrn][addr] = data[0];
   endtask

   task automatic cfg_exit();
      cfg_req = 1'b0;
      step();
      chk("cfg_ack_down", cfg_ack, 1'b0);
      chk("run_in_ready", in_ready, 1'b1);
   endtask

   initial begin
      int acc0, out0, nrn, addr, dat, t;
      rst2 = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
      b_cfg_req = 1'b0; b_cfg_we = 1'b0; b_cfg_neuron = '0; b_cfg_addr = '0; b_cfg_data = '0;
      in_data = '0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
      rnd_stop = 1'b0;

      // reset and cleared tables
      do_reset();
      for (int i = 0; i < 12; i++) send($urandom());
      drain();

      // single table load, then latency of exactly two cycles
      cfg_req = 1'b1;
      wait_cfg_ack();
      cfg_write(2, 8'hB0, 1, 1);
      cfg_exit();
      in_data = 32'h00B0_0000;
      in_valid = 1'b1;
      chk("lat_in_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      chk("lat_cycle1_valid", out_valid, 1'b0);
      step();
      chk("lat_cycle2_valid", out_valid, 1'b1);
      chk("lat_cycle2_data", out_data, 4'b0100);
      drain();

      // backpressure: five inputs, three stalled cycles mid-stream
      out0 = n_out;
      fork
         for (int i = 0; i < 5; i++) send(rnd_small() | 32'h00B0_0000);
         begin
            repeat (3) step();
            out_ready = 1'b0;
            repeat (3) step();
            out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_out_count", n_out - out0, 5);

      // random table contents and random flow control
      cfg_req = 1'b1;
      wait_cfg_ack();
      for (int i = 0; i < 40; i++) begin
         nrn = $urandom_range(0, 3); addr = $urandom_range(0, 15); dat = $urandom_range(0, 1);
         cfg_write(nrn, addr, dat, 1);
      end
      cfg_exit();
      rnd_stop = 1'b0;
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               repeat ($urandom_range(0, 2)) step();
               send(rnd_small());
            end
            rnd_stop = 1'b1;
         end
         begin
            while (!rnd_stop) begin
               out_ready = ($urandom_range(0, 3) != 0);
               step();
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // cfg_req with two results in flight
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_data = rnd_small();
      chk("flight1_in_ready", in_ready, 1'b1);
      step();
      in_data = rnd_small();
      chk("flight2_in_ready", in_ready, 1'b1);
      step();
      acc0 = n_acc; out0 = n_out;
      cfg_req = 1'b1;
      in_data = rnd_small();
      #1;
      chk("req_in_ready", in_ready, 1'b0);
      wait_cfg_ack();
      in_valid = 1'b0;
      chk("req_no_accept", n_acc - acc0, 0);
      chk("req_drained", n_out - out0, 2);
      chk("req_queue_empty", expq.size(), 0);
      cfg_exit();

      // cfg_we outside CFG is ignored
      cfg_write(1, 8'h3C, 1, 0);
      cfg_write(0, 8'h3C, 1, 0);
      send(32'h3C3C_3C3C);
      drain();

      // cfg_req dropped during DRAIN; final CFG cycle write still lands
      out_ready = 1'b0;
      send(rnd_small());
      step();
      cfg_req = 1'b1;
      step();
      cfg_req = 1'b0;
      repeat (3) step();
      chk("drain_busy", busy, 1'b1);
      chk("drain_no_ack", cfg_ack, 1'b0);
      out_ready = 1'b1;
      wait_cfg_ack();
      cfg_write(3, 8'h07, 1, 1);
      chk("late_wr_ack_down", cfg_ack, 1'b0);
      chk("late_wr_in_ready", in_ready, 1'b1);
      send(32'h0700_0000);
      send(32'h07B0_0000);
      drain();

      // reset during CFG clears everything via INIT
      cfg_req = 1'b1;
      wait_cfg_ack();
      rst = 1'b1;
      #1;
      chk("cfgrst_out_valid", out_valid, 1'b0);
      chk("cfgrst_busy", busy, 1'b1);
      chk("cfgrst_cfg_ack", cfg_ack, 1'b0);
      do_reset();
      send(32'h07B0_0000);
      for (int i = 0; i < 10; i++) send(rnd_small());
      drain();

      // out-of-range neuron index on a 3-neuron layer
      repeat (2) step();
      rst2 = 1'b0;
      t = 0;
      while (b_busy && t < 100) begin step(); t++; end
      chk("b_init_cycles", t, 16);
      b_cfg_req = 1'b1;
      t = 0;
      while (!b_cfg_ack && t < 50) begin step(); t++; end
      chk("b_cfg_ack", b_cfg_ack, 1'b1);
      b_cfg_we = 1'b1; b_cfg_neuron = 2'd3; b_cfg_addr = 4'h5; b_cfg_data = 2'd3;
      step();
      b_cfg_neuron = 2'd1; b_cfg_data = 2'd2;
      step();
      b_cfg_we = 1'b0; b_cfg_req = 1'b0;
      step();
      b_in_data = 12'h555; b_in_valid = 1'b1;
      chk("b_in_ready", b_in_ready, 1'b1);
      step();
      b_in_valid = 1'b0;
      step();
      chk("b_out_valid", b_out_valid, 1'b1);
      chk("b_out_data", b_out_data, 6'b00_10_00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
